// File: rtl/bubble_sort_singl.sv
// Sequential bubble sort: one compare/swap unit, one adjacent pair per cycle, ascending unsigned.
// Optional early termination on a swap-free pass when BUBBLE_SORT_EARLY_EXIT_EN is defined.
module bubble_sort_singl #(
    parameter int DIM   = 10,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIM*WIDTH-1:0] data_in,
    output logic [DIM*WIDTH-1:0] data_out,
    output logic                 busy,
    output logic                 done
);

    localparam int            IW     = $clog2(DIM);
    localparam logic [IW-1:0] LAST_P = IW'(DIM - 2);

    typedef enum logic {
        IDLE,
        SORT
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     arr      [DIM];
    logic [WIDTH-1:0]     next_arr [DIM];
    logic [DIM*WIDTH-1:0] next_flat;
    logic [IW-1:0]        p, j, j_nxt, j_end;
    logic [WIDTH-1:0]     elem_lo, elem_hi;
    logic                 do_swap, pass_end, finish;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    logic                 pass_swapped;
`endif

    // The single compare/swap unit; strict > keeps equal elements in order.
    assign j_nxt    = j + IW'(1);
    assign j_end    = LAST_P - p;
    assign elem_lo  = arr[j];
    assign elem_hi  = arr[j_nxt];
    assign do_swap  = elem_lo > elem_hi;
    assign pass_end = (j == j_end);

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    assign finish = pass_end && ((p == LAST_P) || !(pass_swapped || do_swap));
`else
    assign finish = pass_end && (p == LAST_P);
`endif

    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    always_comb begin
        for (int k = 0; k < DIM; k++) next_arr[k] = arr[k];
        if (do_swap) begin
            next_arr[j]     = elem_hi;
            next_arr[j_nxt] = elem_lo;
        end
    end

    always_comb begin
        next_flat = '0;
        for (int k = 0; k < DIM; k++) next_flat[k*WIDTH +: WIDTH] = next_arr[k];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            p        <= '0;
            j        <= '0;
            // NOTE: the working array is cleared on reset because the reset contract
            // requires it; it is small register storage, not a RAM macro.
            for (int k = 0; k < DIM; k++) arr[k] <= '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
            pass_swapped <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < DIM; k++) arr[k] <= data_in[k*WIDTH +: WIDTH];
                        busy  <= 1'b1;
                        p     <= '0;
                        j     <= '0;
                        state <= SORT;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                        pass_swapped <= 1'b0;
`endif
                    end
                end
                SORT: begin
                    for (int k = 0; k < DIM; k++) arr[k] <= next_arr[k];
                    if (finish) begin
                        // Publish the post-swap array of this very comparison.
                        data_out <= next_flat;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        p        <= '0;
                        j        <= '0;
                        state    <= IDLE;
                    end else if (pass_end) begin
                        j <= '0;
                        p <= p + IW'(1);
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                        pass_swapped <= 1'b0;
`endif
                    end else begin
                        j <= j_nxt;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
                        pass_swapped <= pass_swapped | do_swap;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort_singl.sv
// Self-checking bench for bubble_sort_singl: directed and random arrays checked against
// a queue-sort reference, with latency, busy/done protocol and reset behaviour.
module tb_bubble_sort_singl;

    localparam int DIM   = 10;
    localparam int WIDTH = 8;
    localparam int W     = DIM * WIDTH;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic         busy;
    logic         done;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_out;

    always #5 clk = ~clk;

    bubble_sort_singl #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] pack(input int v[DIM]);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIM; i++) r[i*WIDTH +: WIDTH] = WIDTH'(v[i]);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Reference result: ascending unsigned order via a queue sort.
    function automatic logic [W-1:0] model_sort(input logic [W-1:0] din);
        int           q[$];
        logic [W-1:0] r;
        for (int i = 0; i < DIM; i++) q.push_back(int'(din[i*WIDTH +: WIDTH]));
        q.sort();
        r = '0;
        for (int i = 0; i < DIM; i++) r[i*WIDTH +: WIDTH] = WIDTH'(q[i]);
        return r;
    endfunction

    // Reference latency: N comparisons, or with early exit the comparisons up to and
    // including the first pass that finds nothing out of order.
    function automatic int model_latency(input logic [W-1:0] din);
        int a[DIM];
        int n, tmp;
        bit sw;
        if (!EARLY) return DIM * (DIM - 1) / 2;
        for (int i = 0; i < DIM; i++) a[i] = int'(din[i*WIDTH +: WIDTH]);
        n = 0;
        for (int ps = 0; ps < DIM - 1; ps++) begin
            sw = 1'b0;
            for (int k = 0; k < DIM - 1 - ps; k++) begin
                n++;
                if (a[k] > a[k+1]) begin
                    tmp = a[k]; a[k] = a[k+1]; a[k+1] = tmp;
                    sw  = 1'b1;
                end
            end
            if (!sw) break;
        end
        return n;
    endfunction

    task automatic do_reset(input int n);
        rst   = 1'b1;
        start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_out = '0;
        check("reset_data_out", data_out, '0);
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
    endtask

    // One sort: start edge, watch every cycle, check latency/result/protocol.
    // restart_at > 0 pulses a spurious start mid-sort; hold_next keeps start high
    // across the done edge so the following call's start edge is the next one.
    task automatic run_sort(input string tag, input logic [W-1:0] din, input int restart_at,
                            input bit hold_next, input logic [W-1:0] next_din);
        int           lat, got, extra;
        logic [W-1:0] want;
        lat  = model_latency(din);
        want = model_sort(din);
        got  = -1;
        start   = 1'b1;
        data_in = din;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = rand_vec();
        for (int c = 1; c <= 200; c++) begin
            if (c == restart_at) begin
                start   = 1'b1;
                data_in = rand_vec();
            end else if (hold_next && c == lat) begin
                start   = 1'b1;
                data_in = next_din;
            end else if (!(hold_next && c > lat)) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                got = c;
                break;
            end
            check({tag, "_busy_during"}, W'(busy), W'(1));
            check({tag, "_hold_during"}, data_out, exp_out);
        end
        check({tag, "_latency"}, W'(got), W'(lat));
        check({tag, "_result"}, data_out, want);
        check({tag, "_busy_at_done"}, W'(busy), '0);
        exp_out = want;
        if (!hold_next) begin
            start = 1'b0;
            @(posedge clk);
            #1;
            check({tag, "_done_one_cycle"}, W'(done), '0);
            if (restart_at > 0) begin
                extra = 0;
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    if (done) extra++;
                end
                check({tag, "_no_second_done"}, W'(extra), '0);
                check({tag, "_idle_after"}, W'(busy), '0);
                check({tag, "_result_kept"}, data_out, want);
            end
        end
    endtask

    initial begin
        int           v22[DIM] = '{36, 129, 9, 99, 13, 141, 101, 18, 1, 13};
        int           vrev[DIM];
        int           vinc[DIM];
        int           vff[DIM];
        int           vext[DIM];
        int           extra;
        logic [W-1:0] r;
        logic [W-1:0] r2;

        for (int i = 0; i < DIM; i++) begin
            vrev[i] = DIM - 1 - i;
            vinc[i] = i;
            vff[i]  = 255;
            vext[i] = (i % 3 == 0) ? 255 : ((i % 3 == 1) ? 0 : 128);
        end

        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        do_reset(2);

        run_sort("mixed", pack(v22), 0, 1'b0, '0);
        run_sort("reverse", pack(vrev), 0, 1'b0, '0);
        run_sort("ascending", pack(vinc), 0, 1'b0, '0);
        run_sort("all_ff", pack(vff), (model_latency(pack(vff)) > 10) ? 10 : 4, 1'b0, '0);

        // Reset in the middle of a sort: abort, clear outputs, no done afterwards.
        start   = 1'b1;
        data_in = rand_vec();
        @(posedge clk);
        #1;
        start = 1'b0;
        extra = 0;
        repeat (19) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("midreset_no_early_done", W'(extra), '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_out = '0;
        check("midreset_busy", W'(busy), '0);
        check("midreset_done", W'(done), '0);
        check("midreset_data_out", data_out, '0);
        extra = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        check("midreset_stays_idle", W'(extra), '0);

        run_sort("after_reset", rand_vec(), 0, 1'b0, '0);

        // start held across the done edge: only the following edge launches the next sort.
        r  = rand_vec();
        r2 = rand_vec();
        run_sort("chain_a", r, 0, 1'b1, r2);
        run_sort("chain_b", r2, 0, 1'b0, '0);

        run_sort("extremes", pack(vext), 0, 1'b0, '0);
        for (int t = 0; t < 6; t++) begin
            r = rand_vec();
            if (t % 2 == 1)
                for (int i = 0; i < DIM; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 3));
            run_sort("random", r, 0, 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
